// File: rtl/uart_rx_core.sv
// 8N1 asynchronous receiver: synchronised rxd, mid-bit sampling at a
// latched divisor, single held byte with ready/ack and error flags.
module uart_rx_core #(
  parameter int DIVW    = 16,
  parameter int MIN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  input  logic [DIVW-1:0] divr,
  input  logic            rd,
  output logic [7:0]      data,
  output logic            rdy,
  output logic            ferr,
  output logic            oerr,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } st_t;

  st_t             state, nxt;
  logic            s1, s2, rxs;
  logic [DIVW-1:0] d, cnt, dclamp;
  logic [2:0]      bitn;
  logic [7:0]      shreg;
  logic            half_hit, full_hit, done;

  assign rxs      = s2;
  assign dclamp   = (divr < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : divr;
  assign half_hit = (cnt == (d >> 1) - DIVW'(1));
  assign full_hit = (cnt == d - DIVW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (!rxs) nxt = START;
      START: if (half_hit) nxt = rxs ? IDLE : DATA;
      DATA:  if (full_hit && bitn == 3'd7) nxt = STOP;
      STOP:  if (full_hit) nxt = rxs ? IDLE : BRK;
      BRK:   if (rxs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == STOP) && full_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d     <= DIVW'(MIN_DIV);
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) d <= dclamp;
        end
        START: begin
          cnt  <= half_hit ? '0 : cnt + DIVW'(1);
          bitn <= '0;
        end
        DATA: begin
          if (full_hit) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt + DIVW'(1);
          end
        end
        STOP:    cnt <= full_hit ? '0 : cnt + DIVW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // A completion while a byte is still unread drops the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      rdy  <= 1'b0;
      ferr <= 1'b0;
      oerr <= 1'b0;
    end else if (done) begin
      if (!rdy || rd) begin
        data <= shreg;
        rdy  <= 1'b1;
        ferr <= ~rxs;
      end else begin
        oerr <= 1'b1;
      end
    end else if (rd && rdy) begin
      rdy  <= 1'b0;
      ferr <= 1'b0;
      oerr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed table, corner
// sequences and random frames against a frame-level model.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxd;
  logic [15:0] divr;
  logic        rd;
  logic [7:0]  data;
  logic        rdy, ferr, oerr, busy;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic rdy_q = 1'b0;
  int start_cyc;

  uart_rx_core #(.DIVW(16), .MIN_DIV(4)) dut (
    .clk(clk), .rst(rst_n), .rxd(rxd), .divr(divr), .rd(rd),
    .data(data), .rdy(rdy), .ferr(ferr), .oerr(oerr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy && !rdy_q) rise_cyc <= cyc;
    rdy_q <= rdy;
  end

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    int         dv;
    int         dexp;
    logic       ferr_e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  // Drives one frame at bt clk/bit; tail extra bit times held low.
  task automatic send(input logic [7:0] b, input logic stopb,
                      input int bt, input int tail);
    @(negedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bt) @(negedge clk);
    end
    rxd = stopb;
    repeat (bt) @(negedge clk);
    if (tail > 0) begin
      rxd = 1'b0;
      repeat (tail * bt) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  function automatic int lat(input int dd);
    return 3 + (dd >> 1) + 9 * dd;
  endfunction

  function automatic int clampd(input int dv);
    return (dv < 4) ? 4 : dv;
  endfunction

  task automatic recv_check(input string nm, input logic [7:0] b,
                            input logic stopb, input int dv,
                            input int dexp, input logic ferr_e);
    divr = 16'(dv);
    send(b, stopb, dexp, 0);
    repeat (2 * dexp + 4) @(negedge clk);
    chk({nm, " lat"}, rise_cyc - start_cyc, lat(dexp));
    chk({nm, " data"}, data, b);
    chk({nm, " rdy"}, rdy, 1);
    chk({nm, " ferr"}, ferr, ferr_e);
    chk({nm, " oerr"}, oerr, 0);
    chk({nm, " busy"}, busy, 0);
    pulse_rd();
    chk({nm, " rdy_clr"}, rdy, 0);
    chk({nm, " ferr_clr"}, ferr, 0);
  endtask

  initial begin
    vec_t vecs[7];
    rst_n = 1'b0;
    rxd   = 1'b1;
    rd    = 1'b0;
    divr  = 16'd16;
    repeat (3) @(negedge clk);
    chk("rst data", data, 0);
    chk("rst rdy", rdy, 0);
    chk("rst ferr", ferr, 0);
    chk("rst oerr", oerr, 0);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs[0] = '{8'h12, 1'b1, 16, 16, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 16, 16, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 2, 4, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 5, 5, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 7, 7, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 9, 9, 1'b1};
    vecs[6] = '{8'hC3, 1'b1, 0, 4, 1'b0};
    for (int i = 0; i < 7; i++)
      recv_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].stopb,
                 vecs[i].dv, vecs[i].dexp, vecs[i].ferr_e);

    // break: stop bit low, line held low 3 more bit times
    divr = 16'd16;
    send(8'hA5, 1'b0, 16, 3);
    chk("brk busy_low", busy, 1);
    chk("brk lat", rise_cyc - start_cyc, lat(16));
    chk("brk data", data, 8'hA5);
    chk("brk rdy", rdy, 1);
    chk("brk ferr", ferr, 1);
    repeat (6) @(negedge clk);
    chk("brk busy_idle", busy, 0);
    repeat (200) @(negedge clk);
    chk("brk oerr", oerr, 0);
    chk("brk rdy_hold", rdy, 1);
    pulse_rd();
    chk("brk rdy_clr", rdy, 0);

    // false start: 4-cycle glitch
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    chk("glitch busy", busy, 1);
    repeat (10) @(negedge clk);
    chk("glitch idle", busy, 0);
    chk("glitch rdy", rdy, 0);
    recv_check("post_glitch", 8'h3C, 1'b1, 16, 16, 1'b0);

    // overrun
    send(8'h11, 1'b1, 16, 0);
    repeat (36) @(negedge clk);
    send(8'h22, 1'b1, 16, 0);
    repeat (36) @(negedge clk);
    chk("ovr data", data, 8'h11);
    chk("ovr rdy", rdy, 1);
    chk("ovr oerr", oerr, 1);
    pulse_rd();
    chk("ovr rdy_clr", rdy, 0);
    chk("ovr oerr_clr", oerr, 0);

    // rd coincides with the second completion
    send(8'h11, 1'b1, 16, 0);
    repeat (36) @(negedge clk);
    fork
      send(8'h22, 1'b1, 16, 0);
      begin
        @(negedge clk);
        repeat (lat(16) - 1) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    repeat (36) @(negedge clk);
    chk("rdc data", data, 8'h22);
    chk("rdc rdy", rdy, 1);
    chk("rdc oerr", oerr, 0);
    pulse_rd();

    // async reset mid-frame with a byte already held
    send(8'h77, 1'b1, 16, 0);
    repeat (36) @(negedge clk);
    chk("pre_rst rdy", rdy, 1);
    fork
      send(8'h55, 1'b1, 16, 0);
      begin
        repeat (60) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst data", data, 0);
        chk("arst rdy", rdy, 0);
        chk("arst busy", busy, 0);
        chk("arst oerr", oerr, 0);
        #4 rst_n = 1'b1;
      end
    join
    repeat (200) @(negedge clk);
    if (rdy) pulse_rd();
    recv_check("post_rst", 8'h55, 1'b1, 16, 16, 1'b0);

    // random frames against the frame-level model
    for (int i = 0; i < 30; i++) begin
      int dv;
      logic [7:0] b;
      logic sb;
      dv = $urandom_range(1, 12);
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      recv_check($sformatf("rnd%0d", i), b, sb, dv, clampd(dv), ~sb);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
